// File: rtl/mmio_bus_if.sv
// Bus bundle between the CPU data-memory stage, the mmio_bus_ctl decoder and its slaves.
// The "slave" modport is the controller's view; "master" is the view of the CPU plus slave models.
interface mmio_bus_if #(
  parameter int NUM_SLV = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic                  m_req;
  logic                  m_we;
  logic [AW-1:0]         m_addr;
  logic [DW-1:0]         m_wdata;
  logic                  m_ready;
  logic                  m_rvalid;
  logic [DW-1:0]         m_rdata;
  logic                  m_err;
  logic [NUM_SLV-1:0]    s_req;
  logic                  s_we;
  logic [AW-1:0]         s_addr;
  logic [DW-1:0]         s_wdata;
  logic [NUM_SLV-1:0]    s_ack;
  logic [NUM_SLV*DW-1:0] s_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata, s_ack, s_rdata,
    input  m_ready, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_ack, s_rdata,
    output m_ready, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mmio_bus_ctl.sv
// Memory-mapped bus controller: window decode, one-hot slave request, ack/timeout
// handling, registered response and sticky first-error logging.
//
// state | meaning
// IDLE  | m_ready high, waiting for m_req
// BUSY  | s_req[sel] high, waiting for s_ack[sel] or timeout
// RESP  | m_rvalid pulse with m_rdata/m_err
module mmio_bus_ctl #(
  parameter int                    NUM_SLV  = 2,
  parameter int                    AW       = 32,
  parameter int                    DW       = 32,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {32'h0000_0100, 32'h0000_0000},
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00},
  parameter int                    TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst,
  mmio_bus_if.slave     bus,
  output logic          err_sticky,
  output logic [AW-1:0] err_addr,
  input  logic          err_clr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  logic [1:0]    state;
  logic [SW-1:0] sel;
  logic [CW-1:0] cnt;
  logic [AW-1:0] req_addr;

  logic          dec_hit;
  logic [SW-1:0] dec_sel;
  logic [AW-1:0] dec_off;
  logic          sel_ack;
  logic [DW-1:0] sel_rdata;
  logic          timeout;
  logic          accept;
  logic          err_evt;
  logic [AW-1:0] err_evt_addr;

  // Scan from the top so the lowest matching window is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    dec_off = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
        dec_off = bus.m_addr & ~SLV_MASK[i*AW +: AW];
      end
    end
  end

  assign sel_ack   = bus.s_ack[sel];
  assign sel_rdata = bus.s_rdata[sel*DW +: DW];
  assign timeout   = (cnt == CW'(TIMEOUT - 1));
  assign accept    = (state == ST_IDLE) && bus.m_req;

  assign bus.m_ready  = (state == ST_IDLE);
  assign bus.m_rvalid = (state == ST_RESP);

  always_comb begin
    bus.s_req = '0;
    if (state == ST_BUSY) bus.s_req[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= '0;
      cnt         <= '0;
      req_addr    <= '0;
      bus.s_we    <= 1'b0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.m_err   <= 1'b0;
      bus.m_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.m_req) begin
            req_addr <= bus.m_addr;
            if (dec_hit) begin
              sel         <= dec_sel;
              bus.s_we    <= bus.m_we;
              bus.s_addr  <= dec_off;
              bus.s_wdata <= bus.m_wdata;
              cnt         <= '0;
              state       <= ST_BUSY;
            end else begin
              bus.m_err   <= 1'b1;
              bus.m_rdata <= '0;
              state       <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          // An ack on the last allowed cycle beats the timeout.
          if (sel_ack) begin
            bus.m_err   <= 1'b0;
            bus.m_rdata <= bus.s_we ? '0 : sel_rdata;
            state       <= ST_RESP;
          end else if (timeout) begin
            bus.m_err   <= 1'b1;
            bus.m_rdata <= '0;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign err_evt      = (accept && !dec_hit) ||
                        ((state == ST_BUSY) && !sel_ack && timeout);
  assign err_evt_addr = (state == ST_IDLE) ? bus.m_addr : req_addr;

  // A fresh error on the clearing edge is kept as the new first error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (err_evt) begin
      err_sticky <= 1'b1;
      if (!err_sticky || err_clr) err_addr <= err_evt_addr;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctl.sv
// Randomized self-checking bench for mmio_bus_ctl: transaction-level model drives
// per-cycle expectations that a negedge compare process checks against the DUT.
module tb_mmio_bus_ctl;
  localparam int NUM_SLV = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] MDL_BASE [2] = '{32'h0000_0000, 32'h0000_0100};
  localparam logic [31:0] MDL_MASK [2] = '{32'hFFFF_FF00, 32'hFFFF_FF00};

  logic          clk;
  logic          rst;
  logic          err_clr;
  logic          err_sticky;
  logic [AW-1:0] err_addr;

  mmio_bus_if #(.NUM_SLV(NUM_SLV), .AW(AW), .DW(DW)) bus ();

  mmio_bus_ctl #(
    .NUM_SLV (NUM_SLV),
    .AW      (AW),
    .DW      (DW),
    .SLV_BASE({32'h0000_0100, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_FF00, 32'hFFFF_FF00}),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_sticky(err_sticky),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // expected outputs for the current cycle
  logic          exp_ready, exp_rvalid, exp_merr, exp_swe, exp_sticky;
  logic [1:0]    exp_sreq;
  logic [31:0]   exp_mrdata, exp_saddr, exp_swdata, exp_err_addr;

  // observations for literal checks
  int          obs_busy;
  logic [1:0]  obs_sreq;
  logic [31:0] obs_saddr, obs_rdata;
  logic        obs_swe, obs_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", 64'(bus.m_ready), 64'(exp_ready));
      chk("m_rvalid", 64'(bus.m_rvalid), 64'(exp_rvalid));
      chk("s_req", 64'(bus.s_req), 64'(exp_sreq));
      chk("s_we", 64'(bus.s_we), 64'(exp_swe));
      chk("s_addr", 64'(bus.s_addr), 64'(exp_saddr));
      chk("s_wdata", 64'(bus.s_wdata), 64'(exp_swdata));
      chk("err_sticky", 64'(err_sticky), 64'(exp_sticky));
      chk("err_addr", 64'(err_addr), 64'(exp_err_addr));
      if (exp_rvalid) begin
        chk("m_err", 64'(bus.m_err), 64'(exp_merr));
        chk("m_rdata", 64'(bus.m_rdata), 64'(exp_mrdata));
      end
      if (bus.s_req != 2'b00) begin
        obs_busy++;
        obs_sreq  = bus.s_req;
        obs_saddr = bus.s_addr;
        obs_swe   = bus.s_we;
      end
      if (bus.m_rvalid) begin
        obs_rdata = bus.m_rdata;
        obs_err   = bus.m_err;
      end
    end
  end

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NUM_SLV; i++)
      if ((a & MDL_MASK[i]) == MDL_BASE[i]) return i;
    return -1;
  endfunction

  task automatic slave_noise();
    bus.s_ack   = 2'($urandom_range(0, 3));
    bus.s_rdata = {$urandom, $urandom};
  endtask

  task automatic master_noise();
    bus.m_req   = 1'($urandom_range(0, 1));
    bus.m_we    = 1'($urandom_range(0, 1));
    bus.m_addr  = $urandom;
    bus.m_wdata = $urandom;
  endtask

  task automatic set_idle_exp();
    exp_ready  = 1'b1;
    exp_rvalid = 1'b0;
    exp_sreq   = 2'b00;
  endtask

  task automatic reset_exp();
    set_idle_exp();
    exp_merr     = 1'b0;
    exp_mrdata   = '0;
    exp_swe      = 1'b0;
    exp_saddr    = '0;
    exp_swdata   = '0;
    exp_sticky   = 1'b0;
    exp_err_addr = '0;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that ends RESP.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_cyc, input logic [31:0] rd, input logic clr);
    int hit;
    int nbusy;
    logic err;
    logic [31:0] rexp;
    hit   = model_decode(addr);
    err   = (hit < 0) || (ack_cyc > TIMEOUT);
    nbusy = (hit < 0) ? 0 : (err ? TIMEOUT : ack_cyc);
    rexp  = (err || we) ? 32'h0 : rd;
    obs_busy = 0;
    bus.m_req = 1'b1; bus.m_we = we; bus.m_addr = addr; bus.m_wdata = wd;
    err_clr = clr && (nbusy == 0);
    slave_noise();
    @(posedge clk); #1;
    master_noise();
    err_clr = 1'b0;
    if (hit >= 0) begin
      exp_swe    = we;
      exp_saddr  = addr & ~MDL_MASK[hit];
      exp_swdata = wd;
    end
    for (int k = 1; k <= nbusy; k++) begin
      exp_ready  = 1'b0;
      exp_rvalid = 1'b0;
      exp_sreq   = 2'(1 << hit);
      slave_noise();
      bus.s_ack[hit] = (k == ack_cyc);
      bus.s_rdata[hit*32 +: 32] = rd;
      err_clr = clr && (k == nbusy);
      @(posedge clk); #1;
      master_noise();
    end
    err_clr = 1'b0;
    if (err) begin
      if (!exp_sticky || clr) exp_err_addr = addr;
      exp_sticky = 1'b1;
    end else if (clr) begin
      exp_sticky   = 1'b0;
      exp_err_addr = '0;
    end
    exp_ready  = 1'b0;
    exp_rvalid = 1'b1;
    exp_sreq   = 2'b00;
    exp_merr   = err;
    exp_mrdata = rexp;
    slave_noise();
    @(posedge clk); #1;
    bus.m_req = 1'b0;
    slave_noise();
    set_idle_exp();
  endtask

  task automatic idle_cycle(input logic clr);
    bus.m_req = 1'b0;
    err_clr   = clr;
    slave_noise();
    @(posedge clk); #1;
    err_clr = 1'b0;
    if (clr) begin
      exp_sticky   = 1'b0;
      exp_err_addr = '0;
    end
  endtask

  task automatic reset_mid();
    bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 32'h0000_0020; bus.m_wdata = 32'h0;
    bus.s_ack = 2'b00;
    @(posedge clk); #1;
    bus.m_req  = 1'b0;
    exp_ready  = 1'b0;
    exp_rvalid = 1'b0;
    exp_sreq   = 2'b01;
    exp_swe    = 1'b0;
    exp_saddr  = 32'h20;
    exp_swdata = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    reset_exp();
    #1;
    chk("rst_s_req", 64'(bus.s_req), 64'h0);
    chk("rst_m_rvalid", 64'(bus.m_rvalid), 64'h0);
    chk("rst_m_ready", 64'(bus.m_ready), 64'h1);
    chk("rst_m_rdata", 64'(bus.m_rdata), 64'h0);
    chk("rst_m_err", 64'(bus.m_err), 64'h0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    err_clr = 1'b0;
    bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_ack = '0; bus.s_rdata = '0;
    reset_exp();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_ready", 64'(bus.m_ready), 64'h1);
    chk("reset_m_rvalid", 64'(bus.m_rvalid), 64'h0);
    chk("reset_m_rdata", 64'(bus.m_rdata), 64'h0);
    chk("reset_m_err", 64'(bus.m_err), 64'h0);
    chk("reset_s_req", 64'(bus.s_req), 64'h0);
    chk("reset_s_addr", 64'(bus.s_addr), 64'h0);
    chk("reset_err_sticky", 64'(err_sticky), 64'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle_cycle(1'b0);

    run_txn(1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    chk("tp1_busy", 64'(obs_busy), 64'd1);
    chk("tp1_sreq", 64'(obs_sreq), 64'h1);
    chk("tp1_saddr", 64'(obs_saddr), 64'h10);
    chk("tp1_rdata", 64'(obs_rdata), 64'hDEAD_BEEF);
    chk("tp1_err", 64'(obs_err), 64'h0);

    run_txn(1'b1, 32'h0000_0104, 32'h55, 3, 32'h1111_2222, 1'b0);
    chk("tp2_busy", 64'(obs_busy), 64'd3);
    chk("tp2_sreq", 64'(obs_sreq), 64'h2);
    chk("tp2_saddr", 64'(obs_saddr), 64'h04);
    chk("tp2_swe", 64'(obs_swe), 64'h1);
    chk("tp2_rdata", 64'(obs_rdata), 64'h0);
    chk("tp2_err", 64'(obs_err), 64'h0);

    run_txn(1'b0, 32'h0000_0200, 32'h0, 1, 32'h0, 1'b0);
    chk("tp3_busy", 64'(obs_busy), 64'd0);
    chk("tp3_err", 64'(obs_err), 64'h1);
    chk("tp3_sticky", 64'(err_sticky), 64'h1);
    chk("tp3_err_addr", 64'(err_addr), 64'h200);

    idle_cycle(1'b1);
    run_txn(1'b0, 32'h0000_0300, 32'h0, 1, 32'h0, 1'b0);
    run_txn(1'b1, 32'h0000_0400, 32'h9, 1, 32'h0, 1'b0);
    chk("tp5_err_addr_first", 64'(err_addr), 64'h300);
    run_txn(1'b0, 32'h0000_0500, 32'h0, 1, 32'h0, 1'b1);
    chk("tp5_clr_sticky", 64'(err_sticky), 64'h1);
    chk("tp5_clr_err_addr", 64'(err_addr), 64'h500);

    idle_cycle(1'b1);
    run_txn(1'b0, 32'h0000_0030, 32'h0, TIMEOUT + 5, 32'h0, 1'b0);
    chk("tp4_to_busy", 64'(obs_busy), 64'd16);
    chk("tp4_to_err", 64'(obs_err), 64'h1);
    chk("tp4_to_err_addr", 64'(err_addr), 64'h30);
    run_txn(1'b0, 32'h0000_0140, 32'h0, TIMEOUT, 32'h1234_5678, 1'b0);
    chk("tp4_ack16_busy", 64'(obs_busy), 64'd16);
    chk("tp4_ack16_err", 64'(obs_err), 64'h0);
    chk("tp4_ack16_rdata", 64'(obs_rdata), 64'h1234_5678);

    reset_mid();
    run_txn(1'b0, 32'h0000_0010, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
    chk("tp6_rdata", 64'(obs_rdata), 64'hCAFE_F00D);
    chk("tp6_err", 64'(obs_err), 64'h0);

    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      int ack;
      case ($urandom_range(0, 3))
        0: a = {24'h0, 8'($urandom)};
        1: a = {24'h1, 8'($urandom)};
        2: a = $urandom & 32'h0000_0FFF;
        default: a = $urandom;
      endcase
      ack = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                        : int'($urandom_range(1, 5));
      run_txn(1'($urandom_range(0, 1)), a, $urandom, ack, $urandom,
              ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) idle_cycle(($urandom_range(0, 7) == 0));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
